// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: control and data bundles with a valid/ready handshake, flush and an optional skid entry.
// The main entry drives the outputs. SKID=1 keeps in_ready_o in a flop, so ready does not chain combinationally.
module pipe_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 116,
    parameter int SKID   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occ_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              r_state_p1;
    state_t              w_state_nxt;
    logic                r_rdy_p1;
    logic [CTRL_W-1:0]   r_main_ctrl_p1;
    logic [DATA_W-1:0]   r_main_data_p1;
    logic [CTRL_W-1:0]   r_skid_ctrl_p1;
    logic [DATA_W-1:0]   r_skid_data_p1;

    logic                w_rdy_comb;
    logic                w_accept;
    logic                w_send;
    logic                w_ld_main_in;
    logic                w_ld_main_skid;
    logic                w_ld_skid;

    assign out_valid_o = (r_state_p1 != ST_EMPTY);
    assign w_rdy_comb  = !out_valid_o | out_ready_i;
    assign in_ready_o  = (SKID != 0) ? r_rdy_p1 : w_rdy_comb;
    assign w_accept    = in_valid_i & in_ready_o;
    assign w_send      = out_valid_o & out_ready_i;

    // Flush beats everything: held entries and the incoming beat are dropped.
    always_comb begin
        w_state_nxt    = r_state_p1;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (flush_i) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state_p1)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt  = ST_ONE;
                        w_ld_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_send) begin
                        w_ld_main_in = 1'b1;
                    end else if (w_accept && (SKID != 0)) begin
                        w_state_nxt = ST_TWO;
                        w_ld_skid   = 1'b1;
                    end else if (w_send) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_send) begin
                        w_state_nxt    = ST_ONE;
                        w_ld_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Stage register boundary: control state and registered ready.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_p1 <= ST_EMPTY;
            r_rdy_p1   <= 1'b1;
        end else begin
            r_state_p1 <= w_state_nxt;
            r_rdy_p1   <= (w_state_nxt != ST_TWO);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_main_ctrl_p1 <= '0;
            r_main_data_p1 <= '0;
        end else if (w_ld_main_in) begin
            r_main_ctrl_p1 <= in_ctrl_i;
            r_main_data_p1 <= in_data_i;
        end else if (w_ld_main_skid) begin
            r_main_ctrl_p1 <= r_skid_ctrl_p1;
            r_main_data_p1 <= r_skid_data_p1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_ld_skid) begin
            r_skid_ctrl_p1 <= in_ctrl_i;
            r_skid_data_p1 <= in_data_i;
        end
    end

    assign out_ctrl_o = out_valid_o ? r_main_ctrl_p1 : '0;
    assign out_data_o = r_main_data_p1;
    assign occ_o      = r_state_p1;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 instance and one SKID=0 instance, each with its own scoreboard.
module tb_pipe_stage_reg;
    localparam int CW = 8;
    localparam int DW = 116;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          a_in_valid, a_flush, a_out_ready;
    logic [CW-1:0] a_in_ctrl;
    logic [DW-1:0] a_in_data;
    logic          a_in_ready, a_out_valid;
    logic [CW-1:0] a_out_ctrl;
    logic [DW-1:0] a_out_data;
    logic [1:0]    a_occ;

    logic          b_in_valid, b_flush, b_out_ready;
    logic [CW-1:0] b_in_ctrl;
    logic [DW-1:0] b_in_data;
    logic          b_in_ready, b_out_valid;
    logic [CW-1:0] b_out_ctrl;
    logic [DW-1:0] b_out_data;
    logic [1:0]    b_occ;

    int n_pass  = 0;
    int n_total = 0;
    logic [CW+DW-1:0] sb_a[$];
    logic [CW+DW-1:0] sb_b[$];

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u_skid1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
        .in_ctrl_i(a_in_ctrl), .in_data_i(a_in_data), .flush_i(a_flush),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_ctrl_o(a_out_ctrl),
        .out_data_o(a_out_data), .occ_o(a_occ)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u_skid0 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
        .in_ctrl_i(b_in_ctrl), .in_data_i(b_in_data), .flush_i(b_flush),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_ctrl_o(b_out_ctrl),
        .out_data_o(b_out_data), .occ_o(b_occ)
    );

    // Advance one clock; mid-cycle, retire delivered beats against the queues and record accepted ones.
    task automatic tick();
        logic [CW+DW-1:0] exp_v;
        @(negedge clk);
        if (rst) begin
            sb_a.delete();
            sb_b.delete();
        end else begin
            if (a_out_valid && a_out_ready) begin
                n_total++;
                if (sb_a.size() == 0) begin
                    $display("FAIL sb_skid1_unexpected: got %h expected no beat", {a_out_ctrl, a_out_data});
                end else begin
                    exp_v = sb_a.pop_front();
                    if ({a_out_ctrl, a_out_data} !== exp_v)
                        $display("FAIL sb_skid1_beat: got %h expected %h", {a_out_ctrl, a_out_data}, exp_v);
                    else
                        n_pass++;
                end
            end
            if (a_flush) sb_a.delete();
            else if (a_in_valid && a_in_ready) sb_a.push_back({a_in_ctrl, a_in_data});
            if (b_out_valid && b_out_ready) begin
                n_total++;
                if (sb_b.size() == 0) begin
                    $display("FAIL sb_skid0_unexpected: got %h expected no beat", {b_out_ctrl, b_out_data});
                end else begin
                    exp_v = sb_b.pop_front();
                    if ({b_out_ctrl, b_out_data} !== exp_v)
                        $display("FAIL sb_skid0_beat: got %h expected %h", {b_out_ctrl, b_out_data}, exp_v);
                    else
                        n_pass++;
                end
            end
            if (b_flush) sb_b.delete();
            else if (b_in_valid && b_in_ready) sb_b.push_back({b_in_ctrl, b_in_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b1; a_in_ctrl = '0; a_in_data = '0;
        b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1; b_in_ctrl = '0; b_in_data = '0;
        tick();
        tick();
        n_total++; if (a_out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", a_out_valid); else n_pass++;
        n_total++; if (a_out_ctrl !== 8'h00) $display("FAIL reset_ctrl: got %h expected 00", a_out_ctrl); else n_pass++;
        n_total++; if (a_out_data !== '0) $display("FAIL reset_data: got %h expected 0", a_out_data); else n_pass++;
        n_total++; if (a_occ !== 2'd0) $display("FAIL reset_occ: got %0d expected 0", a_occ); else n_pass++;
        n_total++; if (b_occ !== 2'd0) $display("FAIL reset_occ_skid0: got %0d expected 0", b_occ); else n_pass++;
        rst = 1'b0;
        n_total++; if (a_in_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", a_in_ready); else n_pass++;
    endtask

    task automatic test_stream();
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            a_in_ctrl = CW'(i);
            a_in_data = DW'(i);
            tick();
            n_total++; if (a_out_data !== DW'(i)) $display("FAIL stream_data: got %0d expected %0d", a_out_data, i); else n_pass++;
            n_total++; if (a_occ !== 2'd1 || a_in_ready !== 1'b1 || a_out_valid !== 1'b1)
                $display("FAIL stream_state: got occ=%0d rdy=%b vld=%b expected occ=1 rdy=1 vld=1", a_occ, a_in_ready, a_out_valid);
            else n_pass++;
        end
        a_in_valid = 1'b0;
        tick();
        n_total++; if (a_occ !== 2'd0) $display("FAIL stream_drain: got occ=%0d expected 0", a_occ); else n_pass++;
    endtask

    task automatic test_back_pressure();
        a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_ctrl = 8'h11; a_in_data = DW'(8'h11);
        tick();
        a_out_ready = 1'b0; a_in_ctrl = 8'h22; a_in_data = DW'(8'h22);
        tick();
        n_total++; if (a_occ !== 2'd2 || a_in_ready !== 1'b0)
            $display("FAIL bp_full: got occ=%0d rdy=%b expected occ=2 rdy=0", a_occ, a_in_ready);
        else n_pass++;
        a_in_ctrl = 8'h33; a_in_data = DW'(8'h33);
        tick();
        n_total++; if (a_out_data !== DW'(8'h11) || a_out_ctrl !== 8'h11 || a_occ !== 2'd2)
            $display("FAIL bp_stall: got data=%h ctrl=%h occ=%0d expected 11/11/2", a_out_data, a_out_ctrl, a_occ);
        else n_pass++;
        a_out_ready = 1'b1;
        tick();
        n_total++; if (a_out_data !== DW'(8'h22) || a_occ !== 2'd1)
            $display("FAIL bp_release1: got data=%h occ=%0d expected 22/1", a_out_data, a_occ);
        else n_pass++;
        tick();
        n_total++; if (a_out_data !== DW'(8'h33)) $display("FAIL bp_release2: got %h expected 33", a_out_data); else n_pass++;
        a_in_valid = 1'b0;
        tick();
        n_total++; if (a_occ !== 2'd0) $display("FAIL bp_drain: got occ=%0d expected 0", a_occ); else n_pass++;
    endtask

    task automatic test_flush();
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_ctrl = 8'h22; a_in_data = DW'(8'h22);
        tick();
        a_in_ctrl = 8'h33; a_in_data = DW'(8'h33);
        tick();
        n_total++; if (a_occ !== 2'd2) $display("FAIL flush_setup: got occ=%0d expected 2", a_occ); else n_pass++;
        a_flush = 1'b1; a_in_ctrl = 8'h44; a_in_data = DW'(8'h44);
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        n_total++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 8'h00 || a_occ !== 2'd0)
            $display("FAIL flush_full: got vld=%b ctrl=%h occ=%0d expected 0/00/0", a_out_valid, a_out_ctrl, a_occ);
        else n_pass++;
        n_total++; if (a_out_data !== DW'(8'h22)) $display("FAIL flush_data_kept: got %h expected 22", a_out_data); else n_pass++;
        a_out_ready = 1'b1;
        tick();
        tick();
        n_total++; if (a_out_valid !== 1'b0) $display("FAIL flush_no_emit: got vld=%b expected 0", a_out_valid); else n_pass++;
        a_in_valid = 1'b1; a_in_ctrl = 8'h55; a_in_data = DW'(8'h55);
        tick();
        a_flush = 1'b1; a_in_ctrl = 8'h66; a_in_data = DW'(8'h66);
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        n_total++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_out_data !== DW'(8'h55) || a_in_ready !== 1'b1)
            $display("FAIL flush_accept: got vld=%b occ=%0d data=%h rdy=%b expected 0/0/55/1", a_out_valid, a_occ, a_out_data, a_in_ready);
        else n_pass++;
    endtask

    task automatic test_bubble();
        a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_ctrl = 8'hFF; a_in_data = DW'(8'hAB);
        tick();
        n_total++; if (a_out_ctrl !== 8'hFF) $display("FAIL bubble_ctrl_on: got %h expected ff", a_out_ctrl); else n_pass++;
        a_in_valid = 1'b0;
        tick();
        n_total++; if (a_out_ctrl !== 8'h00 || a_out_valid !== 1'b0)
            $display("FAIL bubble_ctrl_off: got ctrl=%h vld=%b expected 00/0", a_out_ctrl, a_out_valid);
        else n_pass++;
        n_total++; if (a_out_data !== DW'(8'hAB)) $display("FAIL bubble_data_kept: got %h expected ab", a_out_data); else n_pass++;
    endtask

    task automatic test_skid0();
        logic [DW-1:0] nxt;
        logic          acc;
        logic          exp_rdy;
        nxt = DW'(100);
        b_in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            b_out_ready = (i % 3) != 1;
            b_in_data   = nxt;
            b_in_ctrl   = CW'(nxt);
            #1;
            exp_rdy = b_out_valid ? b_out_ready : 1'b1;
            n_total++; if (b_in_ready !== exp_rdy) $display("FAIL skid0_ready: got %b expected %b", b_in_ready, exp_rdy); else n_pass++;
            n_total++; if (b_occ > 2'd1) $display("FAIL skid0_occ: got %0d expected <=1", b_occ); else n_pass++;
            acc = b_in_valid & b_in_ready;
            tick();
            if (acc) nxt = nxt + 1'b1;
        end
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        tick();
        tick();
        n_total++; if (b_out_valid !== 1'b0 || sb_b.size() != 0)
            $display("FAIL skid0_drain: got vld=%b pending=%0d expected 0/0", b_out_valid, sb_b.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_ctrl = 8'h77; a_in_data = DW'(8'h77);
        tick();
        a_in_ctrl = 8'h88; a_in_data = DW'(8'h88);
        tick();
        n_total++; if (a_occ !== 2'd2) $display("FAIL rstmid_setup: got occ=%0d expected 2", a_occ); else n_pass++;
        rst = 1'b1; a_in_ctrl = 8'h99; a_in_data = DW'(8'h99);
        tick();
        rst = 1'b0; a_in_valid = 1'b0;
        n_total++; if (a_occ !== 2'd0 || a_out_valid !== 1'b0 || a_out_data !== '0 || a_out_ctrl !== 8'h00)
            $display("FAIL rstmid_clear: got occ=%0d vld=%b data=%h ctrl=%h expected 0/0/0/00", a_occ, a_out_valid, a_out_data, a_out_ctrl);
        else n_pass++;
        a_out_ready = 1'b1;
        tick();
        n_total++; if (a_out_valid !== 1'b0 || sb_a.size() != 0)
            $display("FAIL rstmid_ignored: got vld=%b pending=%0d expected 0/0", a_out_valid, sb_a.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush();
        test_bubble();
        test_skid0();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed ID/EX latch: a generic pipeline stage register carrying a control bundle and a data bundle between two pipeline stages.
- Adds a valid/ready handshake, a back-pressure stall, flush (bubble) capability, and an optional skid entry so that ready does not combinationally chain through the pipeline.
- Used for IF/ID, ID/EX, EX/MEM and MEM/WB by choosing the widths.

Parameters:
- CTRL_W, 8, width of control bundle (ALUOp, ALUSrc, RegWrite, MemWrite, MemRead, MemtoReg, Branch …).
- DATA_W, 116, width of data bundle (rs1/rs2 data, imm, funct, rd/rs/rt addresses).
- SKID, 1, 1 = two-entry (main + skid) registered-ready stage; 0 = single-entry stage with combinational ready.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- in_valid_i  in  1  upstream beat present.
- in_ready_o  out  1  stage can accept a beat this cycle.
- in_ctrl_i  in  CTRL_W  upstream control bundle.
- in_data_i  in  DATA_W  upstream data bundle.
- flush_i  in  1  kill all held beats plus the incoming beat this cycle.
- out_valid_o  out  1  downstream beat present.
- out_ready_i  in  1  downstream accepts the beat.
- out_ctrl_o  out  CTRL_W  control bundle; forced to 0 whenever out_valid_o=0.
- out_data_o  out  DATA_W  data bundle; holds its last value when invalid.
- occ_o  out  2  entries held (0..2; never exceeds 1 when SKID=0).

Behaviour:
- Reset (rst_i=1 at a rising edge): both entries invalid; out_valid_o=0, out_ctrl_o=0, out_data_o=0, occ_o=0. in_ready_o=1 the cycle after reset. rst_i overrides every other input.
- Handshakes:
  - accept = in_valid_i & in_ready_o.
  - send = out_valid_o & out_ready_i.
  - A payload is transferred only on its handshake.
  - Latency is one cycle: an accepted beat is on the outputs from the next edge.
- SKID=1 state machine (EMPTY, ONE, TWO). The main entry drives the outputs; the skid entry holds overflow.
  - EMPTY: accept → ONE (main ← input).
  - ONE: accept & send → ONE (main ← input). accept & !send → TWO (skid ← input). !accept & send → EMPTY. Otherwise hold.
  - TWO: send → ONE (main ← skid). Otherwise hold.
  - in_ready_o = (state != TWO), taken directly from a flop with no combinational path from out_ready_i.
  - Order is preserved; no beat is dropped or duplicated.
- SKID=0: a single entry.
  - in_ready_o = !out_valid_o | out_ready_i (combinational).
  - accept loads the entry.
  - send without accept empties the entry.
- Flush (flush_i=1, rst_i=0):
  - At the next edge, state → EMPTY and occ_o → 0.
  - The incoming beat is discarded even if accept is true that cycle.
  - out_ctrl_o becomes 0, so the stage emits a bubble (RegWrite/MemWrite deasserted).
  - out_data_o is not cleared.
  - Flush takes priority over accept and over send. A send occurring in the flush cycle still counts as delivered downstream.
- Stall: with out_ready_i=0 and out_valid_o=1, out_ctrl_o and out_data_o are stable until send.
- Control gating: out_ctrl_o = out_valid_o ? main_ctrl : 0 at all times.
- occ_o: EMPTY=0, ONE=1, TWO=2.
- No X propagation: skid and main data flops load only on their write enables.

Test Plan:
- Reset then stream (SKID=1): hold rst_i=1 for 2 cycles, then in_valid_i=1 with in_data_i=1,2,3,4 on consecutive cycles and out_ready_i=1 → out_data_o=1,2,3,4 appearing 1 cycle after each accept; occ_o=1; in_ready_o=1 throughout.
- Back-pressure: after beat A=0x11 is held, set out_ready_i=0 and offer B=0x22 then C=0x33 → B accepted, occ_o=2, in_ready_o=0, C held off. Release out_ready_i → outputs 0x11, 0x22, then 0x33 in order, with no loss.
- Flush with full buffer: occ_o=2 holding 0x22/0x33, assert flush_i=1 while in_valid_i=1 with 0x44 → next cycle out_valid_o=0, out_ctrl_o=0, occ_o=0, and 0x44 is never emitted.
- Bubble gating: in_ctrl_i=8'hFF accepted, then in_valid_i=0 with out_ready_i=1 → out_ctrl_o=8'hFF for one cycle, then 8'h00 while out_data_o retains its last value.
- SKID=0 pass-through: out_ready_i toggling 1,0,1 with continuous in_valid_i → in_ready_o follows out_ready_i whenever the entry is full; occ_o never exceeds 1; no beat is lost.
- Reset mid-operation: with occ_o=2 and out_ready_i=0, pulse rst_i=1 together with in_valid_i=1 → next cycle occ_o=0, out_valid_o=0, out_data_o=0, and the input is ignored.
